wb_queue: RTL

WB_QUEUE -- requirements
Module: wb_queue

---
 rtl/wb_queue.sv | 114 +++++++++++
 1 files changed

// File: rtl/wb_queue.sv
// wb_queue: in-order write-back queue between two result producers (ALU and
// load unit) and a single register-file write port.
//
// Ports
//   clock, reset                 sole clock; synchronous active-high reset
//   aluValid/aluReady            ALU write request handshake
//   aluAddr[4:0], aluData[63:0]  ALU destination register and result
//   lsuValid/lsuReady            load-unit write request handshake (priority)
//   lsuAddr[4:0], lsuData[63:0]  load destination register and result
//   wen, wAddr[4:0], wData[63:0] register-file write port (head of queue)
//   busy[31:0]                   bit i set while a queued write targets reg i
//   empty                        no entry queued
//
// The register file accepts a write every cycle, so the head pops on every
// edge the queue is non-empty. Writes to x0 finish the handshake but are
// dropped before reaching storage.
module wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        aluValid,
  output logic        aluReady,
  input  logic [4:0]  aluAddr,
  input  logic [63:0] aluData,
  input  logic        lsuValid,
  output logic        lsuReady,
  input  logic [4:0]  lsuAddr,
  input  logic [63:0] lsuData,
  output logic        wen,
  output logic [4:0]  wAddr,
  output logic [63:0] wData,
  output logic [31:0] busy,
  output logic        empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    addr_q [DEPTH];
  logic [63:0]   data_q [DEPTH];

  logic          full;
  logic          acc_lsu, acc_alu;
  logic [4:0]    push_addr;
  logic [63:0]   push_data;
  logic          push, pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));

  // Readiness looks only at the current count: a pop on the same edge does
  // not open a slot for a full queue.
  assign lsuReady = !full;
  assign aluReady = !full && !lsuValid;

  assign acc_lsu   = lsuValid && lsuReady;
  assign acc_alu   = aluValid && aluReady;
  assign push_addr = acc_lsu ? lsuAddr : aluAddr;
  assign push_data = acc_lsu ? lsuData : aluData;
  assign push      = (acc_lsu || acc_alu) && (push_addr != 5'd0);
  assign pop       = !empty;

  always_comb begin
    head_d = pop  ? head_q + 1'b1 : head_q;
    tail_d = push ? tail_q + 1'b1 : tail_q;
    cnt_d  = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Entry storage is not reset; validity comes from head/count alone.
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      addr_q[tail_q] <= push_addr;
      data_q[tail_q] <= push_data;
    end
  end

  assign wen   = !empty;
  assign wAddr = empty ? 5'd0  : addr_q[head_q];
  assign wData = empty ? 64'd0 : data_q[head_q];

  // An entry is live when its distance from head is below the count.
  always_comb begin
    logic [PW-1:0] off;
    busy = '0;
    off  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - head_q;
      if ({1'b0, off} < cnt_q) busy[addr_q[i]] = 1'b1;
    end
    busy[0] = 1'b0;
  end

endmodule
